// File: rtl/bp_sacc_cmd_dispatch.sv
// Command dispatcher for a bank of accelerator channels: routes commands by a header
// select field, tracks in-flight commands per channel and merges responses round-robin.
module bp_sacc_cmd_dispatch #(
    parameter int num_chan_p        = 4,
    parameter int hdr_width_p       = 64,
    parameter int data_width_p      = 512,
    parameter int sel_lsb_p         = 12,
    parameter int max_outstanding_p = 2
) (
    input  logic                                 clk_i,
    input  logic                                 reset_i,
    input  logic [hdr_width_p-1:0]               cmd_header_i,
    input  logic [data_width_p-1:0]              cmd_data_i,
    input  logic                                 cmd_v_i,
    output logic                                 cmd_ready_and_o,
    input  logic [num_chan_p-1:0]                chan_en_i,
    output logic [hdr_width_p-1:0]               chan_cmd_header_o,
    output logic [data_width_p-1:0]              chan_cmd_data_o,
    output logic [num_chan_p-1:0]                chan_cmd_v_o,
    input  logic [num_chan_p-1:0]                chan_cmd_ready_and_i,
    input  logic [num_chan_p*hdr_width_p-1:0]    chan_resp_header_i,
    input  logic [num_chan_p*data_width_p-1:0]   chan_resp_data_i,
    input  logic [num_chan_p-1:0]                chan_resp_v_i,
    output logic [num_chan_p-1:0]                chan_resp_ready_and_o,
    output logic [hdr_width_p-1:0]               resp_header_o,
    output logic [data_width_p-1:0]              resp_data_o,
    output logic                                 resp_v_o,
    output logic                                 resp_err_o,
    input  logic                                 resp_ready_and_i,
    output logic [num_chan_p-1:0]                busy_o
);
    localparam int sel_width_lp = (num_chan_p > 1) ? $clog2(num_chan_p) : 1;
    localparam int cnt_width_lp = $clog2(max_outstanding_p + 1);
    localparam logic [cnt_width_lp-1:0] max_cnt_lp = cnt_width_lp'(max_outstanding_p);

    logic [sel_width_lp-1:0] sel;
    logic [num_chan_p-1:0][cnt_width_lp-1:0] cnt_reg;
    logic [num_chan_p-1:0] hit, room, cmd_xfer, resp_xfer, grant;
    logic [sel_width_lp-1:0] rr_ptr_reg, grant_idx;
    logic                    valid_tgt, err_accept, err_pend, can_load, resp_take;
    logic                    err_full_reg, buf_v_reg, buf_err_reg;
    logic [hdr_width_p-1:0]  err_hdr_reg, buf_hdr_reg;
    logic [data_width_p-1:0] buf_data_reg;

    assign sel               = cmd_header_i[sel_lsb_p +: sel_width_lp];
    assign chan_cmd_header_o = cmd_header_i;
    assign chan_cmd_data_o   = cmd_data_i;

    // One-hot target decode avoids indexing chan_en_i with an out-of-range select.
    generate
        for (genvar gi = 0; gi < num_chan_p; gi++) begin : g_chan
            assign hit[gi]          = (sel == sel_width_lp'(gi)) & chan_en_i[gi];
            assign room[gi]         = cnt_reg[gi] < max_cnt_lp;
            assign chan_cmd_v_o[gi] = ~reset_i & cmd_v_i & hit[gi] & room[gi];
            assign cmd_xfer[gi]     = chan_cmd_v_o[gi] & chan_cmd_ready_and_i[gi];
            assign resp_xfer[gi]    = chan_resp_ready_and_o[gi] & chan_resp_v_i[gi];
            assign busy_o[gi]       = (cnt_reg[gi] != '0);
        end
    endgenerate

    assign valid_tgt       = |hit;
    assign cmd_ready_and_o = ~reset_i & (valid_tgt ? |(hit & room & chan_cmd_ready_and_i)
                                                   : ~err_full_reg);
    assign err_accept      = cmd_v_i & cmd_ready_and_o & ~valid_tgt;
    // A freshly accepted invalid command counts as an occupied err slot and may go
    // straight into an empty buffer, giving a one-cycle error response.
    assign err_pend        = err_full_reg | err_accept;
    assign can_load        = ~reset_i & (~buf_v_reg | resp_ready_and_i);
    assign resp_take       = can_load & ~err_pend;

    always_comb begin
        int  idx;
        logic found;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int k = 0; k < num_chan_p; k++) begin
            idx = (int'(rr_ptr_reg) + k) % num_chan_p;
            if (!found && chan_resp_v_i[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = sel_width_lp'(idx);
            end
        end
    end

    assign chan_resp_ready_and_o = resp_take ? grant : '0;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_reg      <= '0;
            rr_ptr_reg   <= '0;
            err_full_reg <= 1'b0;
            err_hdr_reg  <= '0;
            buf_v_reg    <= 1'b0;
            buf_err_reg  <= 1'b0;
            buf_hdr_reg  <= '0;
            buf_data_reg <= '0;
        end else begin
            for (int i = 0; i < num_chan_p; i++) begin
                if (cmd_xfer[i] && !resp_xfer[i])
                    cnt_reg[i] <= cnt_reg[i] + 1'b1;
                else if (resp_xfer[i] && !cmd_xfer[i] && cnt_reg[i] != '0)
                    cnt_reg[i] <= cnt_reg[i] - 1'b1;
            end

            if (err_accept && !can_load) begin
                err_full_reg <= 1'b1;
                err_hdr_reg  <= cmd_header_i;
            end else if (err_full_reg && can_load) begin
                err_full_reg <= 1'b0;
            end

            if (can_load) begin
                if (err_pend) begin
                    buf_v_reg    <= 1'b1;
                    buf_err_reg  <= 1'b1;
                    buf_hdr_reg  <= err_full_reg ? err_hdr_reg : cmd_header_i;
                    buf_data_reg <= '0;
                end else if (|grant) begin
                    buf_v_reg    <= 1'b1;
                    buf_err_reg  <= 1'b0;
                    buf_hdr_reg  <= chan_resp_header_i[int'(grant_idx)*hdr_width_p +: hdr_width_p];
                    buf_data_reg <= chan_resp_data_i[int'(grant_idx)*data_width_p +: data_width_p];
                    rr_ptr_reg   <= (int'(grant_idx) == num_chan_p - 1) ? '0 : grant_idx + 1'b1;
                end else begin
                    buf_v_reg   <= 1'b0;
                    buf_err_reg <= 1'b0;
                end
            end
        end
    end

    always @(posedge clk_i) begin
        if (!reset_i) begin
            for (int i = 0; i < num_chan_p; i++)
                assert (!(resp_xfer[i] && cnt_reg[i] == '0))
                    else $error("response from channel %0d with no command outstanding", i);
        end
    end

    assign resp_v_o      = buf_v_reg;
    assign resp_err_o    = buf_err_reg;
    assign resp_header_o = buf_hdr_reg;
    assign resp_data_o   = buf_data_reg;
endmodule

// File: tb/tb_bp_sacc_cmd_dispatch.sv
// Directed bench for bp_sacc_cmd_dispatch with 4 channels, 2 outstanding commands each.
module tb_bp_sacc_cmd_dispatch;
    localparam int N = 4;
    localparam int HW = 64;
    localparam int DW = 512;

    logic              clk_i = 1'b0;
    logic              reset_i;
    logic [HW-1:0]     cmd_header_i;
    logic [DW-1:0]     cmd_data_i;
    logic              cmd_v_i;
    logic              cmd_ready_and_o;
    logic [N-1:0]      chan_en_i;
    logic [HW-1:0]     chan_cmd_header_o;
    logic [DW-1:0]     chan_cmd_data_o;
    logic [N-1:0]      chan_cmd_v_o;
    logic [N-1:0]      chan_cmd_ready_and_i;
    logic [N*HW-1:0]   chan_resp_header_i;
    logic [N*DW-1:0]   chan_resp_data_i;
    logic [N-1:0]      chan_resp_v_i;
    logic [N-1:0]      chan_resp_ready_and_o;
    logic [HW-1:0]     resp_header_o;
    logic [DW-1:0]     resp_data_o;
    logic              resp_v_o;
    logic              resp_err_o;
    logic              resp_ready_and_i;
    logic [N-1:0]      busy_o;

    int checks = 0;
    int errors = 0;

    bp_sacc_cmd_dispatch #(
        .num_chan_p(N), .hdr_width_p(HW), .data_width_p(DW),
        .sel_lsb_p(12), .max_outstanding_p(2)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .cmd_header_i(cmd_header_i), .cmd_data_i(cmd_data_i), .cmd_v_i(cmd_v_i),
        .cmd_ready_and_o(cmd_ready_and_o), .chan_en_i(chan_en_i),
        .chan_cmd_header_o(chan_cmd_header_o), .chan_cmd_data_o(chan_cmd_data_o),
        .chan_cmd_v_o(chan_cmd_v_o), .chan_cmd_ready_and_i(chan_cmd_ready_and_i),
        .chan_resp_header_i(chan_resp_header_i), .chan_resp_data_i(chan_resp_data_i),
        .chan_resp_v_i(chan_resp_v_i), .chan_resp_ready_and_o(chan_resp_ready_and_o),
        .resp_header_o(resp_header_o), .resp_data_o(resp_data_o), .resp_v_o(resp_v_o),
        .resp_err_o(resp_err_o), .resp_ready_and_i(resp_ready_and_i), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [63:0] mk(input int s, input int tag);
        return 64'hA5A5_0000_0000_0000 | (64'(s) << 12) | 64'(tag);
    endfunction

    logic [DW-1:0] d2;
    logic [HW-1:0] he, he2;

    initial begin
        d2 = {8{64'hDEAD_0000_0000_0002}};
        reset_i = 1'b1;
        cmd_header_i = mk(2, 1);
        cmd_data_i = '0;
        cmd_v_i = 1'b1;
        chan_en_i = 4'b1111;
        chan_cmd_ready_and_i = 4'b1111;
        chan_resp_header_i = '0;
        chan_resp_data_i = '0;
        chan_resp_v_i = 4'b1111;
        resp_ready_and_i = 1'b1;
        #2;
        chk("rst_cmd_ready", 64'(cmd_ready_and_o), 0);
        chk("rst_chan_cmd_v", 64'(chan_cmd_v_o), 0);
        chk("rst_chan_resp_ready", 64'(chan_resp_ready_and_o), 0);
        chk("rst_resp_v", 64'(resp_v_o), 0);
        chk("rst_resp_err", 64'(resp_err_o), 0);
        chk("rst_busy", 64'(busy_o), 0);
        tick;
        cmd_v_i = 1'b0;
        chan_resp_v_i = '0;
        tick;
        reset_i = 1'b0;

        // Round-robin: load counters (chan0 x2, chan1..3 x1) then drain all at once.
        for (int i = 0; i < 5; i++) begin
            cmd_header_i = mk((i == 0) ? 0 : i - 1, 16 + i);
            cmd_v_i = 1'b1;
            #1;
            chk($sformatf("load_ready%0d", i), 64'(cmd_ready_and_o), 1);
            tick;
        end
        cmd_v_i = 1'b0;
        chk("load_busy", 64'(busy_o), 4'b1111);
        for (int i = 0; i < N; i++) chan_resp_header_i[i*HW +: HW] = 64'h1000 + 64'(i);
        chan_resp_v_i = 4'b1111;
        #1;
        chk("rr_ready_first", 64'(chan_resp_ready_and_o), 4'b0001);
        chk("rr_resp_v_first", 64'(resp_v_o), 0);
        for (int g = 0; g < 5; g++) begin
            tick;
            if (g == 4) chan_resp_v_i = '0;
            #1;
            chk($sformatf("rr_resp_v%0d", g), 64'(resp_v_o), 1);
            chk($sformatf("rr_hdr%0d", g), resp_header_o, 64'h1000 + 64'(g % 4));
            if (g < 4) chk($sformatf("rr_ready%0d", g), 64'(chan_resp_ready_and_o), 64'(1) << ((g + 1) % 4));
        end
        chk("rr_busy_done", 64'(busy_o), 0);
        tick;
        chk("rr_drained", 64'(resp_v_o), 0);

        // Single command to channel 2, then a stalled response from it.
        cmd_header_i = mk(2, 5);
        cmd_data_i = {16{32'h0BAD_F00D}};
        cmd_v_i = 1'b1;
        chan_cmd_ready_and_i = 4'b0100;
        #1;
        chk("c2_cmd_v", 64'(chan_cmd_v_o), 4'b0100);
        chk("c2_ready", 64'(cmd_ready_and_o), 1);
        chk("c2_hdr_pass", chan_cmd_header_o, mk(2, 5));
        chk("c2_data_pass", 64'(chan_cmd_data_o == {16{32'h0BAD_F00D}}), 1);
        tick;
        cmd_v_i = 1'b0;
        chk("c2_busy", 64'(busy_o), 4'b0100);
        chan_resp_header_i[2*HW +: HW] = 64'h2222_0000_0000_0002;
        chan_resp_data_i[2*DW +: DW] = d2;
        chan_resp_v_i = 4'b0100;
        resp_ready_and_i = 1'b0;
        #1;
        chk("c2_resp_ready", 64'(chan_resp_ready_and_o), 4'b0100);
        tick;
        chan_resp_v_i = 4'b0001;
        chan_resp_header_i[2*HW +: HW] = 64'h3333;
        chan_resp_data_i[2*DW +: DW] = '1;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk($sformatf("hold_v%0d", c), 64'(resp_v_o), 1);
            chk($sformatf("hold_hdr%0d", c), resp_header_o, 64'h2222_0000_0000_0002);
            chk($sformatf("hold_data%0d", c), 64'(resp_data_o == d2), 1);
            chk($sformatf("hold_rdy%0d", c), 64'(chan_resp_ready_and_o), 0);
            tick;
        end
        chk("c2_busy_clear", 64'(busy_o), 0);
        chan_resp_v_i = '0;
        resp_ready_and_i = 1'b1;
        tick;
        chk("c2_drained", 64'(resp_v_o), 0);

        // Outstanding limit on channel 1.
        chan_cmd_ready_and_i = 4'b1111;
        cmd_header_i = mk(1, 7);
        cmd_v_i = 1'b1;
        #1;
        chk("lim_ready1", 64'(cmd_ready_and_o), 1);
        tick;
        chk("lim_ready2", 64'(cmd_ready_and_o), 1);
        tick;
        chk("lim_stall", 64'(cmd_ready_and_o), 0);
        chk("lim_no_v", 64'(chan_cmd_v_o), 0);
        chk("lim_busy", 64'(busy_o), 4'b0010);
        tick;
        chk("lim_stall2", 64'(cmd_ready_and_o), 0);
        chan_resp_v_i = 4'b0010;
        #1;
        chk("lim_resp_ready", 64'(chan_resp_ready_and_o), 4'b0010);
        chk("lim_stall3", 64'(cmd_ready_and_o), 0);
        tick;
        chan_resp_v_i = '0;
        #1;
        chk("lim_resume", 64'(cmd_ready_and_o), 1);
        tick;
        cmd_v_i = 1'b0;
        chan_resp_v_i = 4'b0010;
        tick;
        tick;
        chan_resp_v_i = '0;
        chk("lim_busy_clear", 64'(busy_o), 0);
        tick;
        chk("lim_drained", 64'(resp_v_o), 0);

        // Disabled channel: error responses and the single-entry err slot.
        chan_en_i = 4'b1011;
        resp_ready_and_i = 1'b0;
        he = mk(2, 12'h0E1);
        he2 = mk(2, 12'h0E2);
        cmd_header_i = he;
        cmd_v_i = 1'b1;
        #1;
        chk("err_no_cmd_v", 64'(chan_cmd_v_o), 0);
        chk("err_ready", 64'(cmd_ready_and_o), 1);
        tick;
        cmd_header_i = he2;
        #1;
        chk("err_resp_v", 64'(resp_v_o), 1);
        chk("err_flag", 64'(resp_err_o), 1);
        chk("err_data_zero", 64'(resp_data_o == '0), 1);
        chk("err_hdr", resp_header_o, he);
        chk("err_ready2", 64'(cmd_ready_and_o), 1);
        tick;
        cmd_header_i = mk(2, 12'h0E3);
        resp_ready_and_i = 1'b1;
        #1;
        chk("err_full_refuse", 64'(cmd_ready_and_o), 0);
        chk("err_hdr_hold", resp_header_o, he);
        tick;
        chk("err_slot_hdr", resp_header_o, he2);
        chk("err_slot_flag", 64'(resp_err_o), 1);
        chk("err_refuse_same_cycle_then_free", 64'(cmd_ready_and_o), 1);
        cmd_v_i = 1'b0;
        tick;
        chk("err_drained", 64'(resp_v_o), 0);
        chk("err_flag_clear", 64'(resp_err_o), 0);
        chan_en_i = 4'b1111;

        // Reset with channel 3 saturated and the buffer full.
        cmd_header_i = mk(3, 9);
        cmd_v_i = 1'b1;
        tick;
        tick;
        cmd_header_i = mk(0, 10);
        tick;
        cmd_v_i = 1'b0;
        chan_resp_v_i = 4'b0001;
        resp_ready_and_i = 1'b0;
        tick;
        chan_resp_v_i = '0;
        #1;
        chk("pre_rst_busy", 64'(busy_o), 4'b1000);
        chk("pre_rst_resp_v", 64'(resp_v_o), 1);
        cmd_header_i = mk(3, 11);
        cmd_v_i = 1'b1;
        #1;
        chk("pre_rst_stall", 64'(cmd_ready_and_o), 0);
        #2;
        reset_i = 1'b1;
        #1;
        chk("mid_rst_resp_v", 64'(resp_v_o), 0);
        chk("mid_rst_busy", 64'(busy_o), 0);
        chk("mid_rst_ready", 64'(cmd_ready_and_o), 0);
        chk("mid_rst_cmd_v", 64'(chan_cmd_v_o), 0);
        tick;
        tick;
        reset_i = 1'b0;
        #1;
        chk("post_rst_ready", 64'(cmd_ready_and_o), 1);
        chk("post_rst_cmd_v", 64'(chan_cmd_v_o), 4'b1000);
        tick;
        cmd_v_i = 1'b0;
        chk("post_rst_busy", 64'(busy_o), 4'b1000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/bp_sacc_cmd_dispatch.md
BP_SACC_CMD_DISPATCH -- requirements
Module: bp_sacc_cmd_dispatch

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- num_chan_p, 4, accelerator channel count (1..16)
- hdr_width_p, 64, opaque io header width
- data_width_p, 512, io data width
- sel_lsb_p, 12, LSB of channel-select field in header
- max_outstanding_p, 2, per-channel in-flight command limit (>=1)
REQ-002 sel_width = max(1, clog2(num_chan_p)); select field = cmd_header_i[sel_lsb_p +: sel_width].
REQ-003 Ports SHALL be (name, direction, width, meaning):
- clk_i, in, 1, sole clock
- reset_i, in, 1, asynchronous active-high reset
- cmd_header_i / cmd_data_i / cmd_v_i, in, hdr_width_p / data_width_p / 1, inbound command
- cmd_ready_and_o, out, 1, command accept
- chan_en_i, in, num_chan_p, per-channel enable
- chan_cmd_header_o / chan_cmd_data_o, out, hdr_width_p / data_width_p, broadcast to all channels
- chan_cmd_v_o, out, num_chan_p, one-hot command valid
- chan_cmd_ready_and_i, in, num_chan_p, channel command ready
- chan_resp_header_i / chan_resp_data_i, in, num_chan_p*hdr_width_p / num_chan_p*data_width_p, channel i at slice i
- chan_resp_v_i, in, num_chan_p; chan_resp_ready_and_o, out, num_chan_p
- resp_header_o / resp_data_o / resp_v_o / resp_err_o, out, hdr_width_p / data_width_p / 1 / 1, merged response
- resp_ready_and_i, in, 1, downstream accept
- busy_o, out, num_chan_p, channel outstanding count nonzero

Function
REQ-004 All handshakes SHALL be ready-and-valid; a transfer occurs when v & ready_and are both high on a rising clk_i edge.
REQ-005 Target sel is valid iff sel < num_chan_p and chan_en_i[sel]=1.
REQ-006 Valid target: chan_cmd_v_o[sel] = cmd_v_i & (cnt[sel] < max_outstanding_p); cmd_ready_and_o = chan_cmd_ready_and_i[sel] & (cnt[sel] < max_outstanding_p); zero-latency combinational pass-through; header/data unmodified.
REQ-007 Invalid target: no chan_cmd_v_o asserted; cmd_ready_and_o = ~err_full; on accept, header captured into err slot, err_full set.
REQ-008 Per-channel counter cnt[i] (clog2(max_outstanding_p+1) bits): +1 on command transfer to i, -1 on response transfer from i, unchanged when both occur in the same cycle.
REQ-009 A response from channel i with cnt[i]=0 SHALL leave cnt[i] at 0 and fire a simulation assertion.
REQ-010 Response path SHALL be a single-entry registered output buffer; buffer loads when empty or drained in the same cycle (resp_v_o & resp_ready_and_i), giving one response per cycle sustained and 1-cycle latency.
REQ-011 Load source priority: err slot first (resp_err_o=1, data all-zero, header = captured header), else round-robin among chan_resp_v_i (resp_err_o=0).
REQ-012 Round-robin: search starts at rr_ptr; after granting channel g, rr_ptr = (g+1) mod num_chan_p; rr_ptr unchanged when no channel granted.
REQ-013 chan_resp_ready_and_o SHALL be one-hot at the granted channel only when buffer can load and err slot empty, else all zero.
REQ-014 err_full SHALL clear when err slot loads into the buffer; simultaneous new invalid command is refused that cycle (cmd_ready_and_o=0).
REQ-015 Output buffer contents SHALL be held stable while resp_v_o=1 & resp_ready_and_i=0.
REQ-016 Deasserting chan_en_i[i] with cnt[i]>0 SHALL block new commands to i but still accept and forward its responses.
REQ-017 busy_o[i] = (cnt[i] != 0).

Reset
REQ-018 On reset_i high (async): cnt all 0, rr_ptr 0, err_full 0, buffer empty; resp_v_o=0, resp_err_o=0, busy_o=0.
REQ-019 While reset_i high: cmd_ready_and_o=0, chan_cmd_v_o=0, chan_resp_ready_and_o=0 regardless of inputs.
REQ-020 Reset asserted mid-transfer SHALL discard all in-flight state; first accept no earlier than first edge after deassertion.

Verification (num_chan_p=4, max_outstanding_p=2, sel_lsb_p=12)
REQ-021 Cmd hdr bits[13:12]=2, chan 2 ready -> chan_cmd_v_o=4'b0100 same cycle; busy_o=4'b0100 next cycle.
REQ-022 Three cmds to chan 1 with no responses -> first two accepted, third stalls (cmd_ready_and_o=0) until one chan 1 response transfers.
REQ-023 chan_resp_v_i=4'b1111 continuously, resp_ready_and_i=1 -> grant order 0,1,2,3,0, one per cycle, resp_v_o first high 1 cycle after first grant.
REQ-024 chan_en_i=4'b1011, cmd to chan 2 -> accepted, no chan_cmd_v_o, next cycle resp_v_o=1, resp_err_o=1, data=0, header equal to sent.
REQ-025 resp_ready_and_i=0 for 5 cycles with buffer full -> resp_header_o/resp_data_o stable, chan_resp_ready_and_o=0.
REQ-026 reset_i pulsed with cnt[3]=2 and buffer full -> immediately resp_v_o=0, busy_o=0; after release a cmd to chan 3 is accepted.
